// File: rtl/axil_selftest_master.sv
// AXI4-Lite self-test master: walks C_NUM_REGS registers with a write/read-back/compare
// sequence and reports pass/fail, an error code and the failing register index.
module axil_selftest_master #(
  parameter int                                C_M_AXI_ADDR_WIDTH = 32,
  parameter int                                C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]     C_BASE_ADDR        = '0,
  parameter int                                C_NUM_REGS         = 4,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0]     C_DATA_INCR        = 32'h1111_1111,
  parameter int                                C_TIMEOUT          = 1023
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [2:0]                        err_code,
  output logic [7:0]                        fail_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int         TW       = (C_TIMEOUT < 2) ? 1 : $clog2(C_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(C_TIMEOUT - 1);
  localparam logic [7:0] LAST_IDX = 8'(C_NUM_REGS - 1);

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_BRESP = 3'd1;
  localparam logic [2:0] ERR_RRESP = 3'd2;
  localparam logic [2:0] ERR_DATA  = 3'd3;
  localparam logic [2:0] ERR_TMO   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_CHECK, S_DONE
  } state_t;

  state_t                          state;
  logic [7:0]                      idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   data_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic                            aw_ok, w_ok;
  logic [TW-1:0]                   tmo_cnt;

  logic       aw_hs, w_hs, wr_all, tmo_hit;
  logic [2:0] fail_code;

  // One address register serves both channels; only one transaction is ever in flight.
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = data_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  always_comb begin
    aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
    w_hs      = M_AXI_WVALID & M_AXI_WREADY;
    wr_all    = (aw_ok | aw_hs) & (w_ok | w_hs);
    tmo_hit   = (tmo_cnt == TMO_LAST);
    fail_code = ERR_NONE;
    case (state)
      S_WR:      if (!wr_all && tmo_hit) fail_code = ERR_TMO;
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) fail_code = ERR_BRESP;
        end else if (tmo_hit) fail_code = ERR_TMO;
      end
      S_RD_ADDR: if (!M_AXI_ARREADY && tmo_hit) fail_code = ERR_TMO;
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) fail_code = ERR_RRESP;
        end else if (tmo_hit) fail_code = ERR_TMO;
      end
      S_CHECK:   if (rdata_q != data_q) fail_code = ERR_DATA;
      default:   fail_code = ERR_NONE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= S_IDLE;
      idx           <= '0;
      addr_q        <= C_BASE_ADDR;
      data_q        <= '0;
      rdata_q       <= '0;
      aw_ok         <= 1'b0;
      w_ok          <= 1'b0;
      tmo_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_code      <= ERR_NONE;
      fail_index    <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else if (fail_code != ERR_NONE) begin
      // Any error or timeout abandons the bus; the slave may need a reset to recover.
      state         <= S_DONE;
      busy          <= 1'b0;
      done          <= 1'b1;
      pass          <= 1'b0;
      err_code      <= fail_code;
      fail_index    <= idx;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      if (state == S_RD_DATA && M_AXI_RVALID) rdata_q <= M_AXI_RDATA;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_WR;
            idx           <= '0;
            addr_q        <= C_BASE_ADDR;
            data_q        <= seed;
            aw_ok         <= 1'b0;
            w_ok          <= 1'b0;
            tmo_cnt       <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_code      <= ERR_NONE;
            fail_index    <= '0;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
          end
        end
        S_WR: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_ok         <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_ok         <= 1'b1;
          end
          if (wr_all) begin
            state        <= S_WR_RESP;
            M_AXI_BREADY <= 1'b1;
            tmo_cnt      <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            state         <= S_RD_ADDR;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b1;
            tmo_cnt       <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            state         <= S_RD_DATA;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            tmo_cnt       <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RD_DATA: begin
          if (M_AXI_RVALID) begin
            state        <= S_CHECK;
            M_AXI_RREADY <= 1'b0;
            rdata_q      <= M_AXI_RDATA;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else begin
            state         <= S_WR;
            idx           <= idx + 8'd1;
            addr_q        <= addr_q + C_M_AXI_ADDR_WIDTH'(4);
            data_q        <= data_q + C_DATA_INCR;
            aw_ok         <= 1'b0;
            w_ok          <= 1'b0;
            tmo_cnt       <= '0;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_selftest_master.sv
// Bench for axil_selftest_master: a mirror-memory AXI-Lite slave with fault injection,
// driven from the negative clock edge, and a scoreboard of expected bus accesses.
module tb_axil_selftest_master;

  localparam logic [31:0] INCR = 32'h1111_1111;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN;
  logic        start;
  logic [31:0] seed_in;
  logic        busy, done, pass;
  logic [2:0]  err_code;
  logic [7:0]  fail_index;
  logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 tb_ACLK = ~tb_ACLK;

  axil_selftest_master #(.C_TIMEOUT(15)) dut (
    .M_AXI_ACLK(tb_ACLK), .M_AXI_ARESETN(tb_ARESETN),
    .start(start), .seed(seed_in),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code), .fail_index(fail_index),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: {addr, data} per expected write, addr per expected read.
  logic [63:0] exp_wr[$];
  logic [31:0] exp_rd[$];

  // Fault-injection knobs
  int aw_delay  = 0;
  int flip_idx  = -1;
  int bresp_idx = -1;
  bit ar_block  = 1'b0;

  // Slave state
  logic [31:0] mem [4];
  logic [31:0] aw_lat, w_lat, ar_lat;
  logic [63:0] e;
  bit          aw_got, w_got, ar_got, b_hs, r_hs;
  int          awv_cyc, wv_cyc;
  int          arv_cyc = 0;
  int          wr_seen = 0;
  int          rd_seen = 0;

  // Decisions at the negedge take effect at the next posedge: a handshake recorded here
  // completes at that edge, and its response is presented one cycle later.
  always @(negedge tb_ACLK) begin
    if (!tb_ARESETN) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      bresp = 2'b00; rresp = 2'b00; rdata = '0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
      awv_cyc = 0; wv_cyc = 0;
    end else begin
      if (b_hs) begin bvalid = 1'b0; b_hs = 1'b0; end
      if (r_hs) begin rvalid = 1'b0; r_hs = 1'b0; end
      if (aw_got && w_got) begin
        mem[aw_lat[3:2]] = w_lat;
        wr_seen++;
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(aw_lat), 64'(e[63:32]));
          chk("wr_data", 64'(w_lat), 64'(e[31:0]));
        end
        bvalid = 1'b1;
        bresp  = (int'(aw_lat[9:2]) == bresp_idx) ? 2'b10 : 2'b00;
        aw_got = 1'b0; w_got = 1'b0;
      end
      if (ar_got) begin
        rvalid = 1'b1;
        rresp  = 2'b00;
        rdata  = mem[ar_lat[3:2]] ^ ((int'(ar_lat[9:2]) == flip_idx) ? 32'h1 : 32'h0);
        ar_got = 1'b0;
      end
      if (M_AXI_AWVALID) awv_cyc++;
      awready = M_AXI_AWVALID && (awv_cyc > aw_delay);
      if (awready) begin
        chk("aw_single", 64'(aw_got), 64'd0);
        chk("aw_hold", 64'(awv_cyc), 64'(aw_delay + 1));
        aw_got = 1'b1; aw_lat = M_AXI_AWADDR; awv_cyc = 0;
      end
      wready = 1'b1;
      if (M_AXI_WVALID) begin
        wv_cyc++;
        chk("w_single", 64'(w_got), 64'd0);
        chk("w_hold", 64'(wv_cyc), 64'd1);
        w_got = 1'b1; w_lat = M_AXI_WDATA; wv_cyc = 0;
      end
      if (M_AXI_ARVALID) arv_cyc++;
      arready = M_AXI_ARVALID && !ar_block;
      if (arready) begin
        ar_got = 1'b1; ar_lat = M_AXI_ARADDR; rd_seen++;
        if (exp_rd.size() > 0) chk("rd_addr", 64'(M_AXI_ARADDR), 64'(exp_rd.pop_front()));
      end
      if (bvalid && M_AXI_BREADY) b_hs = 1'b1;
      if (rvalid && M_AXI_RREADY) r_hs = 1'b1;
    end
  end

  function automatic logic [18:0] outs();
    return {busy, done, pass, err_code, fail_index,
            M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY};
  endfunction

  task automatic push_exp(input logic [31:0] s, input int nw, input int nr);
    for (int i = 0; i < nw; i++) exp_wr.push_back({32'(4 * i), s + 32'(i) * INCR});
    for (int i = 0; i < nr; i++) exp_rd.push_back(32'(4 * i));
  endtask

  task automatic pulse_start(input logic [31:0] s);
    @(negedge tb_ACLK);
    start = 1'b1; seed_in = s;
    @(negedge tb_ACLK);
    start = 1'b0; seed_in = '0;
  endtask

  task automatic run(input string tag, input logic [31:0] s, input int nw, input int nr,
                     input bit exp_pass, input int exp_err, input int exp_idx, input bit mid_start);
    int w0, r0;
    w0 = wr_seen; r0 = rd_seen;
    pulse_start(s);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    if (mid_start) begin
      repeat (6) @(negedge tb_ACLK);
      chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
      pulse_start(~s);
    end
    for (int k = 0; k < 500 && !done; k++) begin
      @(posedge tb_ACLK); #1;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_pass"}, 64'(pass), 64'(exp_pass));
    chk({tag, "_err"}, 64'(err_code), 64'(exp_err));
    chk({tag, "_idx"}, 64'(fail_index), 64'(exp_idx));
    chk({tag, "_idle"}, {busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 64'd0);
    chk({tag, "_nwr"}, 64'(wr_seen - w0), 64'(nw));
    chk({tag, "_nrd"}, 64'(rd_seen - r0), 64'(nr));
    chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    chk({tag, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
  endtask

  initial begin
    int a0;
    tb_ARESETN = 1'b0; start = 1'b0; seed_in = '0;
    repeat (3) @(posedge tb_ACLK);
    #1 chk("reset_outs", 64'(outs()), 64'd0);
    @(negedge tb_ACLK); #2 tb_ARESETN = 1'b1;
    repeat (2) @(negedge tb_ACLK);

    // Mirror slave, always ready
    exp_wr.push_back({32'h0, 32'h0101FFFF});
    exp_wr.push_back({32'h4, 32'h12131110});
    exp_wr.push_back({32'h8, 32'h23242221});
    exp_wr.push_back({32'hC, 32'h34353332});
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'(4 * i));
    run("mirror", 32'h0101FFFF, 4, 4, 1'b1, 0, 0, 1'b0);

    // AWREADY three cycles late, WREADY immediate
    aw_delay = 3;
    push_exp(32'hDEAD_BEEF, 4, 4);
    run("bp", 32'hDEAD_BEEF, 4, 4, 1'b1, 0, 0, 1'b0);
    aw_delay = 0;

    // Corrupted read data on register 2; nothing may touch 0xC
    flip_idx = 2;
    push_exp(32'h0000_0001, 3, 3);
    run("flip", 32'h0000_0001, 3, 3, 1'b0, 3, 2, 1'b0);
    flip_idx = -1;

    // SLVERR on the write to register 1; no read of 0x4
    bresp_idx = 1;
    push_exp(32'hFFFF_FFFF, 2, 1);
    run("bresp", 32'hFFFF_FFFF, 2, 1, 1'b0, 1, 1, 1'b0);
    bresp_idx = -1;

    // ARREADY stuck low: ARVALID must stay up exactly C_TIMEOUT cycles
    ar_block = 1'b1;
    a0 = arv_cyc;
    push_exp(32'h1234_5678, 1, 0);
    run("tmo", 32'h1234_5678, 1, 0, 1'b0, 4, 0, 1'b0);
    chk("tmo_arvalid_cycles", 64'(arv_cyc - a0), 64'd15);
    ar_block = 1'b0;

    // Asynchronous reset during register 1's write response
    push_exp(32'hA5A5_0000, 4, 4);
    pulse_start(32'hA5A5_0000);
    for (int k = 0; k < 100 && !(M_AXI_BREADY && M_AXI_AWADDR == 32'h4); k++) begin
      @(posedge tb_ACLK); #1;
    end
    chk("rst_reach_wr_resp1", {M_AXI_BREADY, M_AXI_AWADDR}, {1'b1, 32'h4});
    #2 tb_ARESETN = 1'b0;
    #1 chk("async_reset_outs", 64'(outs()), 64'd0);
    repeat (2) @(negedge tb_ACLK);
    #2 tb_ARESETN = 1'b1;
    exp_wr.delete();
    exp_rd.delete();
    repeat (2) @(negedge tb_ACLK);

    // Clean rerun; a start pulsed mid-run must be ignored
    push_exp(32'h0F0F_F0F0, 4, 4);
    run("restart", 32'h0F0F_F0F0, 4, 4, 1'b1, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
